// File: rtl/wb_slv_pkg.sv
// Shared definitions for the Wishbone mailbox slave.
//   - register addresses (CTRL, DATA, STATUS, CMD)
//   - bit positions inside CTRL, STATUS and CMD
//   - bus FSM state encoding
package wb_slv_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CMD    = 2'd3;

  localparam int CTRL_EN_BIT   = 7;
  localparam int CTRL_IE_BIT   = 6;

  localparam int ST_FULL_BIT   = 7;
  localparam int ST_EMPTY_BIT  = 6;
  localparam int ST_OVF_BIT    = 5;
  localparam int ST_UDF_BIT    = 4;

  localparam int CMD_FLUSH_BIT = 0;
  localparam int CMD_CLR_BIT   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } bus_state_e;

endpackage

// File: rtl/wb_slv_fifo.sv
// Single-clock mailbox FIFO.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   push_i, wdata_i   write request and data (ignored when full)
//   pop_i             read request (ignored when empty)
//   flush_i           empties the FIFO; wins over push/pop on the same edge
//   rdata_o           head entry (meaningful only when not empty)
//   count_o           exact occupancy 0..FIFO_DEPTH
//   full_o, empty_o   occupancy flags
module wb_slv_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [3:0]            count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int              PW     = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]      DEPTH4 = 4'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [3:0]            r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (r_count == DEPTH4);
  assign empty_o   = (r_count == 4'd0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_do_push && !flush_i) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_mailbox_slave.sv
// Wishbone classic slave exposing a loopback mailbox through four byte registers.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i  Wishbone cycle, strobe, write enable
//   adr_i, dat_i        register address (bits [1:0] decoded) and write data
//   ack_o, dat_o        one-cycle acknowledge and read data (0 unless acking a read)
//   irq_o               registered level interrupt
//   dbg_state_o         bus FSM state for observation
//
// Handshake: a request is cyc_i&stb_i sampled high in IDLE. The slave answers
// with exactly one ack_o cycle WAIT_STATES+1 cycles later; the register side
// effect commits on the edge that ends that ack cycle. After ack the slave waits
// for stb_i low before accepting another request, so a held strobe commits once.
// Dropping cyc_i or stb_i while waiting cancels the access without side effects.
module wb_mailbox_slave
  import wb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_STATES = 0,
  parameter int IRQ_THRESH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o,
  output logic [1:0]            dbg_state_o
);

  localparam logic [3:0] WS4     = 4'(WAIT_STATES);
  localparam logic [3:0] THRESH4 = 4'(IRQ_THRESH);

  bus_state_e            r_state;
  logic [3:0]            r_wcnt;
  logic                  r_we;
  logic [1:0]            r_adr;
  logic [DATA_WIDTH-1:0] r_wdat;
  logic                  r_ack;
  logic                  r_en;
  logic                  r_ie;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_irq;

  logic                  w_commit;
  logic                  w_data_acc;
  logic                  w_push_req;
  logic                  w_pop_req;
  logic                  w_flush;
  logic                  w_clr;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;
  logic [3:0]            w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_rd8;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_unused = ^adr_i;

  // All side effects are qualified by the single ACK cycle.
  assign w_commit   = (r_state == S_ACK);
  assign w_data_acc = w_commit & (r_adr == REG_DATA) & r_en;
  assign w_push_req = w_data_acc & r_we;
  assign w_pop_req  = w_data_acc & ~r_we;
  assign w_flush    = w_commit & r_we & (r_adr == REG_CMD) & r_wdat[CMD_FLUSH_BIT];
  assign w_clr      = w_commit & r_we & (r_adr == REG_CMD) & r_wdat[CMD_CLR_BIT];

  wb_slv_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push_req),
    .pop_i   (w_pop_req),
    .flush_i (w_flush),
    .wdata_i (r_wdat),
    .rdata_o (w_fifo_rdata),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      r_we    <= 1'b0;
      r_adr   <= 2'd0;
      r_wdat  <= '0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cyc_i && stb_i) begin
            r_adr  <= adr_i[1:0];
            r_we   <= we_i;
            r_wdat <= dat_i;
            r_wcnt <= WS4;
            if (WS4 == 4'd0) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!(cyc_i && stb_i)) begin
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
            // Counter reaches zero on this edge.
            if (r_wcnt == 4'd1) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        S_ACK: begin
          r_state <= S_HOLD;
          r_ack   <= 1'b0;
        end
        S_HOLD: begin
          if (!stb_i) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_commit && r_we && (r_adr == REG_CTRL)) begin
        r_en <= r_wdat[CTRL_EN_BIT];
        r_ie <= r_wdat[CTRL_IE_BIT];
      end
      if (w_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (w_push_req && w_full)  r_ovf <= 1'b1;
        if (w_pop_req  && w_empty) r_udf <= 1'b1;
      end
      r_irq <= r_ie & ((r_en & (w_count >= THRESH4)) | r_ovf | r_udf);
    end
  end

  always_comb begin
    w_rd8 = 8'h00;
    case (r_adr)
      REG_CTRL: begin
        w_rd8[CTRL_EN_BIT] = r_en;
        w_rd8[CTRL_IE_BIT] = r_ie;
      end
      REG_STATUS: begin
        w_rd8[ST_FULL_BIT]  = w_full;
        w_rd8[ST_EMPTY_BIT] = w_empty;
        w_rd8[ST_OVF_BIT]   = r_ovf;
        w_rd8[ST_UDF_BIT]   = r_udf;
        w_rd8[3:0]          = w_count;
      end
      default: w_rd8 = 8'h00;
    endcase
    w_rdata = DATA_WIDTH'(w_rd8);
    // Disabled or empty mailbox reads as zero.
    if ((r_adr == REG_DATA) && r_en && !w_empty) w_rdata = w_fifo_rdata;
  end

  assign ack_o       = r_ack;
  assign dat_o       = (r_ack && !r_we) ? w_rdata : '0;
  assign irq_o       = r_irq;
  assign dbg_state_o = r_state;

endmodule
